ext_mem_sched: RTL and testbench
================================

Name: ext_mem_sched

Overview:
- Sequential successor to the combinational memory decoder.
- Arbitrates one external SRAM/ROM port between the instruction-fetch path and the CPU data path.
- Decodes a parametrised peripheral window into per-channel strobes.
- Inserts a configurable number of SRAM wait states and returns a registered ack/data handshake to each requester.

Parameters:
- DW, 16, data width.
- AW, 16, address width.
- WAIT_STATES, 1, extra strobe cycles per external access (0..15).
- PERIPH_BASE, 12'hFDF, upper AW-4 address bits selecting the peripheral window.
- NPERIPH, 9, number of peripheral channels (1..16), mapped at offsets 0..NPERIPH-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  AW  fetch address.
- if_ack  out  1  one-cycle pulse, fetch complete.
- if_data  out  DW  fetched word, valid with if_ack and held until the next fetch ack.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ack  out  1  one-cycle pulse, data access complete.
- d_rdata  out  DW  load data, valid with d_ack and held until the next data ack.
- SRAM_CE  out  1  active-low chip enable.
- SRAM_OE  out  1  active-low output enable.
- SRAM_WE  out  1  active-low write enable.
- EXT_MEM_ADDR  out  AW  external address.
- EXT_MEM_DOUT  out  DW  external write data.
- EXT_MEM_DIN  in  DW  external read data.
- periph_re  out  NPERIPH  per-channel read strobe.
- periph_we  out  NPERIPH  per-channel write strobe.
- periph_wdata  out  DW  peripheral write data.
- periph_rdata  in  NPERIPH*DW  flattened read data; channel k occupies bits [k*DW +: DW].

Behaviour:
- All outputs are registered.
- Reset values:
  - SRAM_CE, SRAM_OE, SRAM_WE = 1.
  - All other outputs = 0.
  - FSM in IDLE.
- Reset asserted mid-access: strobes deassert immediately (asynchronous), no ack is issued, and the pending request is re-arbitrated after reset release.
- FSM states: IDLE, EXT, PERIPH, ACK.
- IDLE:
  - Samples if_req and d_req.
  - Fetch wins on conflict.
  - A data request whose d_addr[AW-1:4] equals PERIPH_BASE goes to PERIPH; all other requests go to EXT.
  - The winning address, data and direction are latched on the transition.
- EXT:
  - SRAM_CE = 0 for exactly WAIT_STATES+1 cycles, counted by a 4-bit counter.
  - Read: SRAM_OE = 0, SRAM_WE = 1.
  - Write: SRAM_WE = 0, SRAM_OE = 1, EXT_MEM_DOUT = latched wdata.
  - EXT_MEM_ADDR is stable for the whole state.
  - EXT_MEM_DIN is captured on the last strobe cycle.
  - Next state: ACK.
- PERIPH:
  - Exactly one cycle.
  - Offset o = latched addr[3:0].
  - If o < NPERIPH: load pulses periph_re[o] and captures periph_rdata channel o; store pulses periph_we[o] with periph_wdata = wdata.
  - If o >= NPERIPH: no strobe, read data = 0.
  - External strobes stay deasserted.
  - Next state: ACK.
- ACK:
  - Strobes deasserted (one turnaround cycle).
  - Pulses the owner's ack for one cycle.
  - Updates if_data or d_rdata; store acks leave d_rdata unchanged.
  - Next state: IDLE.
- Latency, with the request first sampled in IDLE at cycle 0:
  - External access: ack at cycle WAIT_STATES+2; minimum back-to-back period WAIT_STATES+3.
  - Peripheral access: ack at cycle 2.
- A request dropped before its ack is a protocol violation. The access still completes and acks.
- Simultaneous if_req and d_req in IDLE: fetch is served first; data is served on the next IDLE visit.
- Fetches are never decoded as peripheral and always go to EXT.

Optional Feature:
- Macro: EXT_MEM_SCHED_RR_EN.
- Defined: a 1-bit last-grant register (reset = data) alternates the winner when both requests are pending in IDLE. This bounds data starvation to one fetch.
- Undefined: fixed fetch priority; a continuous fetch stream can starve data indefinitely.

Test Plan:
- Reset, then a fetch from 16'h0100 with EXT_MEM_DIN = 16'hBEEF and WAIT_STATES = 1:
  - SRAM_CE = 0 and SRAM_OE = 0 for cycles 1-2 with EXT_MEM_ADDR = 16'h0100.
  - if_ack at cycle 3 with if_data = 16'hBEEF.
- Data store to 16'h2000 with data 16'h1234:
  - SRAM_WE = 0 for 2 cycles, EXT_MEM_DOUT = 16'h1234, SRAM_OE = 1.
  - d_ack at cycle 3; d_rdata unchanged.
- Load from 16'hFDF2 with channel 2 rdata = 16'h00A5:
  - periph_re = 9'b000000100 for 1 cycle.
  - d_ack at cycle 2 with d_rdata = 16'h00A5.
  - SRAM_CE stays 1.
- Load from 16'hFDFC (unmapped offset, NPERIPH = 9):
  - No strobe, d_ack at cycle 2, d_rdata = 0.
- if_req and d_req asserted together, both held:
  - Without the macro: fetch acks first, data acks WAIT_STATES+3 cycles later.
  - With the macro and if_req held continuously: grants alternate fetch/data.
- reset asserted during the EXT strobe cycle:
  - SRAM_CE, SRAM_OE, SRAM_WE return to 1 before the next clk edge.
  - No ack; after release the held request restarts and acks normally.

Source files
------------

// File: rtl/ext_mem_sched.sv
// Shares one external SRAM/ROM port between instruction fetch and CPU data, decodes a
// peripheral window into per-channel strobes. Define EXT_MEM_SCHED_RR_EN for round-robin arbitration.
`timescale 1ns/1ps
module ext_mem_sched #(
  parameter int            DW          = 16,
  parameter int            AW          = 16,
  parameter int            WAIT_STATES = 1,
  parameter logic [AW-5:0] PERIPH_BASE = 12'hFDF,
  parameter int            NPERIPH     = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [AW-1:0]         if_addr,
  output logic                  if_ack,
  output logic [DW-1:0]         if_data,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [AW-1:0]         d_addr,
  input  logic [DW-1:0]         d_wdata,
  output logic                  d_ack,
  output logic [DW-1:0]         d_rdata,
  output logic                  SRAM_CE,
  output logic                  SRAM_OE,
  output logic                  SRAM_WE,
  output logic [AW-1:0]         EXT_MEM_ADDR,
  output logic [DW-1:0]         EXT_MEM_DOUT,
  input  logic [DW-1:0]         EXT_MEM_DIN,
  output logic [NPERIPH-1:0]    periph_re,
  output logic [NPERIPH-1:0]    periph_we,
  output logic [DW-1:0]         periph_wdata,
  input  logic [NPERIPH*DW-1:0] periph_rdata
);
  localparam logic [3:0] LP_WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_PERIPH, S_ACK} state_t;

  state_t             r_state, w_state_nx;
  logic [3:0]         r_cnt, w_cnt_nx;
  logic [3:0]         r_off, w_off_nx;
  logic               r_fetch, w_fetch_nx;
  logic               r_we, w_we_nx;
  logic               w_pick_d, w_periph_hit;
  logic               w_ce_nx, w_oe_nx, w_wen_nx, w_if_ack_nx, w_d_ack_nx;
  logic [AW-1:0]      w_addr_nx;
  logic [DW-1:0]      w_dout_nx, w_if_data_nx, w_d_rdata_nx, w_pwdata_nx, w_prd;
  logic [NPERIPH-1:0] w_pre_nx, w_pwe_nx;

`ifdef EXT_MEM_SCHED_RR_EN
  logic r_last_d, w_last_d_nx;
  // On conflict the side that did not win last time gets the port.
  assign w_pick_d = d_req & (~if_req | ~r_last_d);
`else
  assign w_pick_d = d_req & ~if_req;
`endif
  // Only data accesses can reach the peripheral window.
  assign w_periph_hit = w_pick_d & (d_addr[AW-1:4] == PERIPH_BASE);

  always_comb begin
    w_prd = '0;
    for (int k = 0; k < NPERIPH; k++)
      if (r_off == 4'(k)) w_prd = periph_rdata[k*DW +: DW];
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_off_nx     = r_off;
    w_fetch_nx   = r_fetch;
    w_we_nx      = r_we;
    w_ce_nx      = 1'b1;
    w_oe_nx      = 1'b1;
    w_wen_nx     = 1'b1;
    w_if_ack_nx  = 1'b0;
    w_d_ack_nx   = 1'b0;
    w_addr_nx    = EXT_MEM_ADDR;
    w_dout_nx    = EXT_MEM_DOUT;
    w_if_data_nx = if_data;
    w_d_rdata_nx = d_rdata;
    w_pwdata_nx  = periph_wdata;
    w_pre_nx     = '0;
    w_pwe_nx     = '0;
`ifdef EXT_MEM_SCHED_RR_EN
    w_last_d_nx  = r_last_d;
`endif
    case (r_state)
      S_IDLE: begin
        if (if_req | d_req) begin
          w_fetch_nx = ~w_pick_d;
          w_we_nx    = w_pick_d & d_we;
          w_off_nx   = d_addr[3:0];
`ifdef EXT_MEM_SCHED_RR_EN
          w_last_d_nx = w_pick_d;
`endif
          if (w_periph_hit) begin
            w_state_nx = S_PERIPH;
            for (int k = 0; k < NPERIPH; k++)
              if (d_addr[3:0] == 4'(k)) begin
                w_pre_nx[k] = ~d_we;
                w_pwe_nx[k] = d_we;
              end
            if (d_we) w_pwdata_nx = d_wdata;
          end else begin
            w_state_nx = S_EXT;
            w_cnt_nx   = '0;
            w_ce_nx    = 1'b0;
            w_oe_nx    = w_pick_d & d_we;
            w_wen_nx   = ~(w_pick_d & d_we);
            w_addr_nx  = w_pick_d ? d_addr : if_addr;
            if (w_pick_d & d_we) w_dout_nx = d_wdata;
          end
        end
      end
      S_EXT: begin
        if (r_cnt == LP_WS) begin
          // Last strobe cycle: sample the SRAM and drop the strobes for turnaround.
          w_state_nx  = S_ACK;
          w_if_ack_nx = r_fetch;
          w_d_ack_nx  = ~r_fetch;
          if (r_fetch)    w_if_data_nx = EXT_MEM_DIN;
          else if (!r_we) w_d_rdata_nx = EXT_MEM_DIN;
        end else begin
          w_cnt_nx = r_cnt + 4'd1;
          w_ce_nx  = SRAM_CE;
          w_oe_nx  = SRAM_OE;
          w_wen_nx = SRAM_WE;
        end
      end
      S_PERIPH: begin
        w_state_nx = S_ACK;
        w_d_ack_nx = 1'b1;
        if (!r_we) w_d_rdata_nx = w_prd;
      end
      S_ACK:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_off        <= '0;
      r_fetch      <= 1'b0;
      r_we         <= 1'b0;
      SRAM_CE      <= 1'b1;
      SRAM_OE      <= 1'b1;
      SRAM_WE      <= 1'b1;
      if_ack       <= 1'b0;
      d_ack        <= 1'b0;
      if_data      <= '0;
      d_rdata      <= '0;
      EXT_MEM_ADDR <= '0;
      EXT_MEM_DOUT <= '0;
      periph_re    <= '0;
      periph_we    <= '0;
      periph_wdata <= '0;
`ifdef EXT_MEM_SCHED_RR_EN
      r_last_d     <= 1'b1;
`endif
    end else begin
      r_cnt        <= w_cnt_nx;
      r_off        <= w_off_nx;
      r_fetch      <= w_fetch_nx;
      r_we         <= w_we_nx;
      SRAM_CE      <= w_ce_nx;
      SRAM_OE      <= w_oe_nx;
      SRAM_WE      <= w_wen_nx;
      if_ack       <= w_if_ack_nx;
      d_ack        <= w_d_ack_nx;
      if_data      <= w_if_data_nx;
      d_rdata      <= w_d_rdata_nx;
      EXT_MEM_ADDR <= w_addr_nx;
      EXT_MEM_DOUT <= w_dout_nx;
      periph_re    <= w_pre_nx;
      periph_we    <= w_pwe_nx;
      periph_wdata <= w_pwdata_nx;
`ifdef EXT_MEM_SCHED_RR_EN
      r_last_d     <= w_last_d_nx;
`endif
    end
  end
endmodule

// File: tb/tb_ext_mem_sched.sv
// Bench for ext_mem_sched: latency-rule reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_ext_mem_sched;
  localparam int DW = 16, AW = 16, WS = 1, NP = 9;
  localparam logic [11:0] PB = 12'hFDF;

  logic clk = 1'b0, reset = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, EXT_MEM_DIN = '0;
  logic [NP*DW-1:0] periph_rdata;
  logic if_ack, d_ack, SRAM_CE, SRAM_OE, SRAM_WE;
  logic [DW-1:0] if_data, d_rdata, EXT_MEM_DOUT, periph_wdata;
  logic [AW-1:0] EXT_MEM_ADDR;
  logic [NP-1:0] periph_re, periph_we;

  ext_mem_sched #(.DW(DW), .AW(AW), .WAIT_STATES(WS), .PERIPH_BASE(PB), .NPERIPH(NP)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .SRAM_CE(SRAM_CE), .SRAM_OE(SRAM_OE), .SRAM_WE(SRAM_WE),
    .EXT_MEM_ADDR(EXT_MEM_ADDR), .EXT_MEM_DOUT(EXT_MEM_DOUT), .EXT_MEM_DIN(EXT_MEM_DIN),
    .periph_re(periph_re), .periph_we(periph_we), .periph_wdata(periph_wdata), .periph_rdata(periph_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: one transaction at a time, described by cycles elapsed since its grant.
  logic m_busy = 1'b0, m_fetch = 1'b0, m_periph = 1'b0, m_we = 1'b0, m_lastd = 1'b1, m_pick_d;
  int m_k = 0, m_ackk = 0, m_o;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_cap = '0, m_if_data = '0, m_d_rdata = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_k = 0; m_lastd = 1'b1; m_if_data = '0; m_d_rdata = '0;
    end else if (!m_busy) begin
      if (if_req || d_req) begin
`ifdef EXT_MEM_SCHED_RR_EN
        m_pick_d = d_req && (!if_req || !m_lastd);
`else
        m_pick_d = d_req && !if_req;
`endif
        m_lastd  = m_pick_d;
        m_fetch  = !m_pick_d;
        m_addr   = m_pick_d ? d_addr : if_addr;
        m_we     = m_pick_d && d_we;
        m_wdata  = d_wdata;
        m_periph = m_pick_d && (d_addr[15:4] == PB);
        m_ackk   = m_periph ? 2 : WS + 2;
        m_busy   = 1'b1;
        m_k      = 1;
      end
    end else if (m_k == m_ackk) begin
      m_busy = 1'b0;
    end else begin
      if (!m_periph && m_k == WS + 1) m_cap = EXT_MEM_DIN;
      if (m_periph) begin
        m_o = int'(m_addr[3:0]);
        m_cap = (m_o < NP) ? periph_rdata[m_o*DW +: DW] : '0;
      end
      m_k++;
      if (m_k == m_ackk && !m_we) begin
        if (m_fetch) m_if_data = m_cap;
        else         m_d_rdata = m_cap;
      end
    end
  end

  logic e_ext;
  logic [NP-1:0] e_re, e_we;
  always @(negedge clk) begin
    e_ext = m_busy && !m_periph && m_k >= 1 && m_k <= WS + 1;
    e_re = '0;
    e_we = '0;
    if (m_busy && m_periph && m_k == 1 && int'(m_addr[3:0]) < NP) begin
      if (m_we) e_we[m_addr[3:0]] = 1'b1;
      else      e_re[m_addr[3:0]] = 1'b1;
    end
    chk("SRAM_CE", SRAM_CE, !e_ext);
    chk("SRAM_OE", SRAM_OE, !(e_ext && !m_we));
    chk("SRAM_WE", SRAM_WE, !(e_ext && m_we));
    chk("if_ack", if_ack, m_busy && m_k == m_ackk && m_fetch);
    chk("d_ack", d_ack, m_busy && m_k == m_ackk && !m_fetch);
    chk("if_data", if_data, m_if_data);
    chk("d_rdata", d_rdata, m_d_rdata);
    chk("periph_re", periph_re, e_re);
    chk("periph_we", periph_we, e_we);
    if (e_ext) chk("EXT_MEM_ADDR", EXT_MEM_ADDR, m_addr);
    if (e_ext && m_we) chk("EXT_MEM_DOUT", EXT_MEM_DOUT, m_wdata);
    if (e_we != '0) chk("periph_wdata", periph_wdata, m_wdata);
  end

  // Issues one request, returns the cycle its ack appears (-1 on timeout), then spends the turnaround cycle.
  task automatic do_req(input logic fetch, input logic [15:0] addr, input logic we,
                        input logic [15:0] wd, output int lat);
    lat = -1;
    if (fetch) begin if_req = 1'b1; if_addr = addr; end
    else begin d_req = 1'b1; d_addr = addr; d_we = we; d_wdata = wd; end
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if ((fetch && if_ack) || (!fetch && d_ack)) begin lat = c; break; end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
  endtask

  int lat, fa, da, nacks;
  int order[3];

  initial begin
    for (int k = 0; k < NP; k++) periph_rdata[k*DW +: DW] = 16'h1100 + 16'(k);
    periph_rdata[2*DW +: DW] = 16'h00A5;
    @(negedge clk); @(negedge clk);
    chk("reset CE", SRAM_CE, 1'b1);
    chk("reset OE", SRAM_OE, 1'b1);
    chk("reset WE", SRAM_WE, 1'b1);
    chk("reset addr", EXT_MEM_ADDR, 16'h0000);
    reset = 1'b0;

    // Fetch from 0100, two strobe cycles, ack at cycle 3.
    EXT_MEM_DIN = 16'hBEEF;
    if_req = 1'b1; if_addr = 16'h0100;
    @(negedge clk);
    chk("fetch c1 CE", SRAM_CE, 1'b0); chk("fetch c1 OE", SRAM_OE, 1'b0);
    chk("fetch c1 addr", EXT_MEM_ADDR, 16'h0100);
    @(negedge clk);
    chk("fetch c2 CE", SRAM_CE, 1'b0); chk("fetch c2 OE", SRAM_OE, 1'b0);
    @(negedge clk);
    chk("fetch c3 ack", if_ack, 1'b1); chk("fetch c3 data", if_data, 16'hBEEF);
    chk("fetch c3 CE", SRAM_CE, 1'b1);
    if_req = 1'b0;
    @(negedge clk);

    do_req(1'b0, 16'hFDF2, 1'b0, 16'h0, lat);
    chk("periph load lat", lat, 2); chk("periph load data", d_rdata, 16'h00A5);
    do_req(1'b0, 16'h2000, 1'b1, 16'h1234, lat);
    chk("ext store lat", lat, 3); chk("store keeps rdata", d_rdata, 16'h00A5);
    do_req(1'b0, 16'hFDFC, 1'b0, 16'h0, lat);
    chk("unmapped lat", lat, 2); chk("unmapped data", d_rdata, 16'h0000);
    do_req(1'b0, 16'hFDF5, 1'b1, 16'h5A5A, lat);
    chk("periph store lat", lat, 2);
    EXT_MEM_DIN = 16'hC0DE;
    do_req(1'b0, 16'h3000, 1'b0, 16'h0, lat);
    chk("ext load lat", lat, 3); chk("ext load data", d_rdata, 16'hC0DE);

    // Simultaneous requests: fetch first, data one access period later.
    EXT_MEM_DIN = 16'h7777;
    fa = -1; da = -1;
    if_req = 1'b1; if_addr = 16'h0200;
    d_req = 1'b1; d_addr = 16'h0300; d_we = 1'b0;
    for (int c = 1; c <= 40 && (fa < 0 || da < 0); c++) begin
      @(negedge clk);
      if (if_ack) begin fa = c; if_req = 1'b0; end
      if (d_ack)  begin da = c; d_req = 1'b0; end
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("conflict fetch lat", fa, 3);
    chk("conflict data lat", da, 3 + WS + 3);

    // Fetch held continuously against a pending data request: record who is served.
    nacks = 0;
    order = '{-1, -1, -1};
    if_req = 1'b1; if_addr = 16'h0400;
    d_req = 1'b1; d_addr = 16'h0500; d_we = 1'b0;
    for (int c = 1; c <= 60 && nacks < 3; c++) begin
      @(negedge clk);
      if (if_ack) begin order[nacks] = 0; nacks++; end
      if (d_ack)  begin order[nacks] = 1; nacks++; d_req = 1'b0; end
    end
    if_req = 1'b0;
    for (int c = 1; c <= 30 && d_req; c++) begin
      @(negedge clk);
      if (d_ack) d_req = 1'b0;
    end
    chk("starve data drained", d_req, 1'b0);
    d_req = 1'b0;
    @(negedge clk);
`ifdef EXT_MEM_SCHED_RR_EN
    chk("grant0", order[0], 0); chk("grant1", order[1], 1); chk("grant2", order[2], 0);
`else
    chk("grant0", order[0], 0); chk("grant1", order[1], 0); chk("grant2", order[2], 0);
`endif

    // Reset during the strobe: strobes drop at once, held fetch restarts afterwards.
    EXT_MEM_DIN = 16'h4444;
    if_req = 1'b1; if_addr = 16'h0600;
    @(negedge clk);
    chk("pre-reset CE", SRAM_CE, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async CE", SRAM_CE, 1'b1); chk("async OE", SRAM_OE, 1'b1); chk("async WE", SRAM_WE, 1'b1);
    @(negedge clk);
    chk("no ack in reset", if_ack, 1'b0);
    reset = 1'b0;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (if_ack) begin lat = c; break; end
    end
    if_req = 1'b0;
    chk("restart lat", lat, 3); chk("restart data", if_data, 16'h4444);
    @(negedge clk); @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
